// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Moves a sprite across the visible area, advancing its position once every
//   (frame_div+1) frames. The sprite reflects off the screen edges, and each
//   reflection is reported as a bounce event. Firmware can load a new position
//   and velocity through a valid/ready port.
//
//   Ports:
//     clk_pix, reset (async, active-low)
//     frame_int             end-of-frame level from the timing stage
//     pause, frame_div      motion suppression and frame divider
//     load_valid/ready      load handshake; load_x/y, load_vx/vy carry the data
//     offset_x/offset_y     registered sprite position
//     bounce_x/bounce_y     one-cycle reflection pulses
//     bounce_count          reflection total (wraps)
//     frame_count           frame_int rising-edge total (wraps)
module sprite_motion_ctrl #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 480,
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 64,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0,
  parameter int INIT_VX  = 1,
  parameter int INIT_VY  = 1
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        frame_int,
  input  logic        pause,
  input  logic [3:0]  frame_div,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_x,
  input  logic [15:0] load_y,
  input  logic [7:0]  load_vx,
  input  logic [7:0]  load_vy,
  output logic [15:0] offset_x,
  output logic [15:0] offset_y,
  output logic        bounce_x,
  output logic        bounce_y,
  output logic [15:0] bounce_count,
  output logic [15:0] frame_count
);

  localparam logic signed [16:0] MAX_X = 17'(SCREEN_W - SPRITE_W);
  localparam logic signed [16:0] MAX_Y = 17'(SCREEN_H - SPRITE_H);

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

  typedef struct packed {
    logic [15:0] pos;
    logic [7:0]  vel;
    logic        hit;
  } step_t;

  // One axis step with reflection. The position is always within [0, maxv] and
  // |v| <= 127, so 17-bit signed math cannot overflow.
  function automatic step_t step_axis(input logic [15:0] pos, input logic [7:0] v,
                                      input logic signed [16:0] maxv);
    logic signed [16:0] s;
    step_t r;
    s     = $signed({1'b0, pos}) + $signed({{9{v[7]}}, v});
    r.pos = s[15:0];
    r.vel = v;
    r.hit = 1'b0;
    if (s < 17'sd0) begin
      r.pos = 16'(-s);
      r.vel = -v;
      r.hit = 1'b1;
    end else if (s > maxv) begin
      r.pos = 16'((maxv <<< 1) - s);
      r.vel = -v;
      r.hit = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [15:0] clamp_pos(input logic [15:0] v, input logic signed [16:0] maxv);
    if (v[15])                       return 16'd0;
    else if ($signed({1'b0, v}) > maxv) return maxv[15:0];
    else                             return v;
  endfunction

  // -128 has no positive counterpart, so a reflection of it would stay negative.
  function automatic logic [7:0] sat_vel(input logic [7:0] v);
    return (v == 8'h80) ? 8'h81 : v;
  endfunction

  state_t      state_q, state_d;
  logic        frame_int_q, frame_int_d;
  logic        tick_q, tick_d;
  logic [3:0]  div_cnt_q, div_cnt_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [7:0]  vx_q, vx_d, vy_q, vy_d;
  logic [15:0] nx_q, nx_d, ny_q, ny_d;
  logic [7:0]  nvx_q, nvx_d, nvy_q, nvy_d;
  logic        hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic        bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
  logic [15:0] bounce_count_q, bounce_count_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        load_ready_q, load_ready_d;

  step_t step_x_r, step_y_r;
  assign step_x_r = step_axis(x_q, vx_q, MAX_X);
  assign step_y_r = step_axis(y_q, vy_q, MAX_Y);

  always_comb begin
    state_d        = state_q;
    frame_int_d    = frame_int;
    // The tick is registered, which gives the edge-detect stage of the pipeline.
    tick_d         = frame_int & ~frame_int_q;
    div_cnt_d      = div_cnt_q;
    x_d            = x_q;
    y_d            = y_q;
    vx_d           = vx_q;
    vy_d           = vy_q;
    nx_d           = nx_q;
    ny_d           = ny_q;
    nvx_d          = nvx_q;
    nvy_d          = nvy_q;
    hit_x_d        = hit_x_q;
    hit_y_d        = hit_y_q;
    bounce_x_d     = 1'b0;
    bounce_y_d     = 1'b0;
    bounce_count_d = bounce_count_q;
    frame_count_d  = frame_count_q + {15'd0, tick_q};

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          x_d       = clamp_pos(load_x, MAX_X);
          y_d       = clamp_pos(load_y, MAX_Y);
          vx_d      = sat_vel(load_vx);
          vy_d      = sat_vel(load_vy);
          div_cnt_d = 4'd0;
        end else if (tick_q && !pause) begin
          if (div_cnt_q >= frame_div) begin
            div_cnt_d = 4'd0;
            state_d   = STEP_X;
          end else begin
            div_cnt_d = div_cnt_q + 4'd1;
          end
        end
      end
      STEP_X: begin
        nx_d    = step_x_r.pos;
        nvx_d   = step_x_r.vel;
        hit_x_d = step_x_r.hit;
        state_d = STEP_Y;
      end
      STEP_Y: begin
        ny_d    = step_y_r.pos;
        nvy_d   = step_y_r.vel;
        hit_y_d = step_y_r.hit;
        state_d = COMMIT;
      end
      COMMIT: begin
        x_d            = nx_q;
        y_d            = ny_q;
        vx_d           = nvx_q;
        vy_d           = nvy_q;
        bounce_x_d     = hit_x_q;
        bounce_y_d     = hit_y_q;
        bounce_count_d = bounce_count_q + {15'd0, hit_x_q} + {15'd0, hit_y_q};
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    load_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      frame_int_q    <= 1'b0;
      tick_q         <= 1'b0;
      div_cnt_q      <= 4'd0;
      x_q            <= 16'(INIT_X);
      y_q            <= 16'(INIT_Y);
      vx_q           <= 8'(INIT_VX);
      vy_q           <= 8'(INIT_VY);
      nx_q           <= 16'(INIT_X);
      ny_q           <= 16'(INIT_Y);
      nvx_q          <= 8'(INIT_VX);
      nvy_q          <= 8'(INIT_VY);
      hit_x_q        <= 1'b0;
      hit_y_q        <= 1'b0;
      bounce_x_q     <= 1'b0;
      bounce_y_q     <= 1'b0;
      bounce_count_q <= 16'd0;
      frame_count_q  <= 16'd0;
      load_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      frame_int_q    <= frame_int_d;
      tick_q         <= tick_d;
      div_cnt_q      <= div_cnt_d;
      x_q            <= x_d;
      y_q            <= y_d;
      vx_q           <= vx_d;
      vy_q           <= vy_d;
      nx_q           <= nx_d;
      ny_q           <= ny_d;
      nvx_q          <= nvx_d;
      nvy_q          <= nvy_d;
      hit_x_q        <= hit_x_d;
      hit_y_q        <= hit_y_d;
      bounce_x_q     <= bounce_x_d;
      bounce_y_q     <= bounce_y_d;
      bounce_count_q <= bounce_count_d;
      frame_count_q  <= frame_count_d;
      load_ready_q   <= load_ready_d;
    end
  end

  assign offset_x     = x_q;
  assign offset_y     = y_q;
  assign bounce_x     = bounce_x_q;
  assign bounce_y     = bounce_y_q;
  assign bounce_count = bounce_count_q;
  assign frame_count  = frame_count_q;
  assign load_ready   = load_ready_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl. Each moving frame pushes its expected position
// and bounce flags to a scoreboard; the entry is popped when the update is due.
module tb_sprite_motion_ctrl;
  logic        clk_pix = 1'b0;
  logic        reset = 1'b0;
  logic        frame_int = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  frame_div = 4'd0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_x = '0, load_y = '0;
  logic [7:0]  load_vx = '0, load_vy = '0;
  logic [15:0] offset_x, offset_y;
  logic        bounce_x, bounce_y;
  logic [15:0] bounce_count, frame_count;

  sprite_motion_ctrl dut (
    .clk_pix(clk_pix), .reset(reset), .frame_int(frame_int), .pause(pause),
    .frame_div(frame_div), .load_valid(load_valid), .load_ready(load_ready),
    .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
    .offset_x(offset_x), .offset_y(offset_y), .bounce_x(bounce_x),
    .bounce_y(bounce_y), .bounce_count(bounce_count), .frame_count(frame_count)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        bx;
    logic        by;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] cur_x = 16'd0, cur_y = 16'd0;
  logic [15:0] n_ticks = 16'd0;

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic bx, input logic by);
    exp_t e;
    e.x = x; e.y = y; e.bx = bx; e.by = by;
    sb.push_back(e);
  endtask

  // Drive one frame_int pulse and check the 4-edge update timing.
  task automatic tick(input bit move);
    exp_t e;
    @(negedge clk_pix) frame_int = 1'b1;
    n_ticks = n_ticks + 16'd1;
    @(posedge clk_pix);                 // first edge sampling frame_int high
    @(posedge clk_pix); @(posedge clk_pix); #1;
    if (move) begin
      checks++;
      if (load_ready !== 1'b0) begin
        failures++; $display("FAIL busy_ready got=%b want=0", load_ready);
      end
    end
    @(posedge clk_pix); #1;
    checks++;
    if (offset_x !== cur_x || offset_y !== cur_y) begin
      failures++; $display("FAIL early_update got=(%0d,%0d) want=(%0d,%0d)", offset_x, offset_y, cur_x, cur_y);
    end
    @(posedge clk_pix); #1;
    if (move) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL scoreboard_empty got=0 entries want>=1");
      end else begin
        e = sb.pop_front();
        if (offset_x !== e.x || offset_y !== e.y || bounce_x !== e.bx || bounce_y !== e.by) begin
          failures++;
          $display("FAIL update got=(%0d,%0d,bx=%b,by=%b) want=(%0d,%0d,bx=%b,by=%b)",
                   offset_x, offset_y, bounce_x, bounce_y, e.x, e.y, e.bx, e.by);
        end
        cur_x = e.x; cur_y = e.y;
      end
    end else begin
      checks++;
      if (offset_x !== cur_x || offset_y !== cur_y || bounce_x !== 1'b0 || bounce_y !== 1'b0) begin
        failures++;
        $display("FAIL no_move got=(%0d,%0d,bx=%b,by=%b) want=(%0d,%0d,0,0)",
                 offset_x, offset_y, bounce_x, bounce_y, cur_x, cur_y);
      end
    end
    @(posedge clk_pix); #1;
    checks++;
    if (bounce_x !== 1'b0 || bounce_y !== 1'b0) begin
      failures++; $display("FAIL bounce_width got=(%b,%b) want=(0,0)", bounce_x, bounce_y);
    end
    @(negedge clk_pix) frame_int = 1'b0;
    repeat (2) @(negedge clk_pix);
  endtask

  task automatic do_load(input logic [15:0] x, input logic [15:0] y, input logic [7:0] vx,
                         input logic [7:0] vy, input logic [15:0] ex, input logic [15:0] ey);
    @(negedge clk_pix);
    load_valid = 1'b1; load_x = x; load_y = y; load_vx = vx; load_vy = vy;
    @(posedge clk_pix); #1;
    checks++;
    if (offset_x !== ex || offset_y !== ey) begin
      failures++; $display("FAIL load got=(%0d,%0d) want=(%0d,%0d)", offset_x, offset_y, ex, ey);
    end
    cur_x = ex; cur_y = ey;
    @(negedge clk_pix) load_valid = 1'b0;
  endtask

  task automatic check_bcount(input logic [15:0] want);
    checks++;
    if (bounce_count !== want) begin
      failures++; $display("FAIL bounce_count got=%0d want=%0d", bounce_count, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk_pix);
    checks++;
    if (offset_x !== 16'd0 || offset_y !== 16'd0 || load_ready !== 1'b1 || bounce_x !== 1'b0 ||
        bounce_y !== 1'b0 || bounce_count !== 16'd0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset got=(%0d,%0d,rdy=%b,bx=%b,by=%b,bc=%0d,fc=%0d) want=(0,0,1,0,0,0,0)",
               offset_x, offset_y, load_ready, bounce_x, bounce_y, bounce_count, frame_count);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk_pix);
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) begin
      push(16'(i), 16'(i), 1'b0, 1'b0);
      tick(1'b1);
    end
    checks++;
    if (frame_count !== 16'd3) begin
      failures++; $display("FAIL frame_count_basic got=%0d want=3", frame_count);
    end
    check_bcount(16'd0);
  endtask

  task automatic test_bounce_right();
    do_load(16'd730, 16'd100, 8'd5, 8'd0, 16'd730, 16'd100);
    push(16'd735, 16'd100, 1'b0, 1'b0); tick(1'b1);
    push(16'd732, 16'd100, 1'b1, 1'b0); tick(1'b1);
    check_bcount(16'd1);
    push(16'd727, 16'd100, 1'b0, 1'b0); tick(1'b1);   // velocity is now -5
  endtask

  task automatic test_bounce_left();
    do_load(16'd2, 16'd100, 8'hFB, 8'd0, 16'd2, 16'd100);
    push(16'd3, 16'd100, 1'b1, 1'b0); tick(1'b1);
    push(16'd8, 16'd100, 1'b0, 1'b0); tick(1'b1);
    check_bcount(16'd2);
  endtask

  task automatic test_corner();
    do_load(16'd735, 16'd415, 8'd3, 8'd3, 16'd735, 16'd415);
    push(16'd734, 16'd414, 1'b1, 1'b1); tick(1'b1);
    check_bcount(16'd4);
  endtask

  task automatic test_frame_div_pause();
    logic [15:0] fc0;
    do_load(16'd100, 16'd100, 8'd1, 8'd1, 16'd100, 16'd100);
    frame_div = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      if (i % 3 == 0) begin
        push(16'(100 + i / 3), 16'(100 + i / 3), 1'b0, 1'b0);
        tick(1'b1);
      end else begin
        tick(1'b0);
      end
    end
    pause = 1'b1;
    fc0 = frame_count;
    for (int i = 0; i < 4; i++) tick(1'b0);
    checks++;
    if (frame_count !== fc0 + 16'd4) begin
      failures++; $display("FAIL frame_count_pause got=%0d want=%0d", frame_count, fc0 + 16'd4);
    end
    pause = 1'b0;
    tick(1'b0); tick(1'b0);
    push(16'd103, 16'd103, 1'b0, 1'b0); tick(1'b1);
    frame_div = 4'd0;
  endtask

  task automatic test_load_tick();
    @(negedge clk_pix);
    load_valid = 1'b1; load_x = 16'd900; load_y = 16'hFFFD; load_vx = 8'h80; load_vy = 8'd0;
    @(negedge clk_pix) frame_int = 1'b1;
    n_ticks = n_ticks + 16'd1;
    repeat (6) @(negedge clk_pix);
    frame_int = 1'b0;
    repeat (6) @(negedge clk_pix);
    checks++;
    if (offset_x !== 16'd736 || offset_y !== 16'd0 || bounce_x !== 1'b0 || bounce_y !== 1'b0) begin
      failures++;
      $display("FAIL load_tick got=(%0d,%0d,bx=%b,by=%b) want=(736,0,0,0)", offset_x, offset_y, bounce_x, bounce_y);
    end
    load_valid = 1'b0;
    cur_x = 16'd736; cur_y = 16'd0;
    push(16'd609, 16'd0, 1'b0, 1'b0); tick(1'b1);   // velocity saturated to -127
    checks++;
    if (frame_count !== n_ticks) begin
      failures++; $display("FAIL frame_count_total got=%0d want=%0d", frame_count, n_ticks);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_pix) frame_int = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (offset_x !== 16'd0 || offset_y !== 16'd0 || load_ready !== 1'b1 ||
        bounce_count !== 16'd0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid got=(%0d,%0d,rdy=%b,bc=%0d,fc=%0d) want=(0,0,1,0,0)",
               offset_x, offset_y, load_ready, bounce_count, frame_count);
    end
    frame_int = 1'b0;
    @(negedge clk_pix) reset = 1'b1;
    repeat (2) @(negedge clk_pix);
    cur_x = 16'd0; cur_y = 16'd0; n_ticks = 16'd0;
    push(16'd1, 16'd1, 1'b0, 1'b0); tick(1'b1);
    checks++;
    if (frame_count !== 16'd1) begin
      failures++; $display("FAIL frame_count_after_reset got=%0d want=1", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce_right();
    test_bounce_left();
    test_corner();
    test_frame_div_pause();
    test_load_tick();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
